// File: rtl/bootloader_top.sv
// bootloader_top: UART-framed commands drive SPI flash transfers; a break aborts, command 0x00 requests warmboot.
module bootloader_top #(
  parameter int CLK_FREQ      = 12000000,
  parameter int UART_BAUDRATE = 115200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic uart0_rx,
  output logic uart0_tx,
  output logic spi_sck,
  output logic spi_so,
  input  logic spi_si,
  output logic spi_ss,
  output logic boot
);
  localparam int BIT = CLK_FREQ / UART_BAUDRATE;
  localparam int TW  = $clog2(BIT);
  localparam int BRK = 16 * BIT;
  localparam int BW  = $clog2(BRK + 1);
  typedef enum logic [2:0] {IDLE, TXL0, TXL1, RXL0, RXL1, XFER_TX, XFER_RX, BOOT} state_t;
  state_t r_state, w_next;
  logic [1:0] r_rx_s;
  logic [BW-1:0] r_brk_cnt;
  logic r_rx_busy, r_rx_vld;
  logic [3:0] r_rx_bit;
  logic [TW-1:0] r_rx_tick;
  logic [7:0] r_rx_sr;
  logic r_tx_full;
  logic [7:0] r_tx_hold;
  logic [9:0] r_tx_sh;
  logic [3:0] r_tx_bits;
  logic [TW-1:0] r_tx_tick;
  logic r_spi_busy, r_spi_done, r_sck, r_so;
  logic [3:0] r_spi_cnt;
  logic [6:0] r_spi_sr;
  logic [7:0] r_spi_in;
  logic [15:0] r_tx_len, r_rx_len;
  logic r_ss, r_boot;
  logic w_rx, w_in_brk, w_brk_hit, w_tx_end, w_tx_load, w_spi_start, w_tx_q;
  logic [7:0] w_spi_data;
  assign w_rx      = r_rx_s[1];
  assign w_in_brk  = r_brk_cnt == BW'(BRK);
  assign w_brk_hit = !w_rx && r_brk_cnt == BW'(BRK - 1);
  assign w_tx_end  = r_tx_tick == TW'(BIT - 1);
  assign w_tx_load = r_tx_full && (r_tx_bits == 4'd0 || (r_tx_bits == 4'd1 && w_tx_end));
  assign uart0_tx  = r_tx_sh[0];
  assign spi_sck   = r_sck;
  assign spi_so    = r_so;
  assign spi_ss    = r_ss;
  assign boot      = r_boot;
  // Receiver stays idle for the whole break until the line returns high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s    <= 2'b11;
      r_brk_cnt <= '0;
      r_rx_busy <= 1'b0;
      r_rx_vld  <= 1'b0;
      r_rx_bit  <= 4'd0;
      r_rx_tick <= '0;
      r_rx_sr   <= 8'h00;
    end else begin
      r_rx_s    <= {r_rx_s[0], uart0_rx};
      r_brk_cnt <= w_rx ? '0 : w_in_brk ? r_brk_cnt : r_brk_cnt + 1'b1;
      r_rx_vld  <= 1'b0;
      if (w_in_brk || w_brk_hit) r_rx_busy <= 1'b0;
      else if (!r_rx_busy) begin
        r_rx_busy <= !w_rx;
        r_rx_tick <= '0;
        r_rx_bit  <= 4'd0;
      end else if (r_rx_tick != (r_rx_bit == 4'd0 ? TW'(BIT / 2 - 1) : TW'(BIT - 1))) r_rx_tick <= r_rx_tick + 1'b1;
      else begin
        r_rx_tick <= '0;
        r_rx_bit  <= r_rx_bit + 1'b1;
        if (r_rx_bit == 4'd0) r_rx_busy <= !w_rx;
        else if (r_rx_bit == 4'd9) begin
          r_rx_busy <= 1'b0;
          r_rx_vld  <= w_rx;
        end else r_rx_sr <= {w_rx, r_rx_sr[7:1]};
      end
    end
  end
  // Reloading on the final stop-bit tick keeps consecutive bytes gap-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_full <= 1'b0;
      r_tx_hold <= 8'h00;
      r_tx_sh   <= '1;
      r_tx_bits <= 4'd0;
      r_tx_tick <= '0;
    end else begin
      if (w_tx_load) begin
        r_tx_sh   <= {1'b1, r_tx_hold, 1'b0};
        r_tx_bits <= 4'd10;
        r_tx_tick <= '0;
      end else if (r_tx_bits != 4'd0) begin
        r_tx_tick <= w_tx_end ? '0 : r_tx_tick + 1'b1;
        r_tx_sh   <= w_tx_end ? {1'b1, r_tx_sh[9:1]} : r_tx_sh;
        r_tx_bits <= w_tx_end ? r_tx_bits - 1'b1 : r_tx_bits;
      end
      if (w_tx_q) begin
        r_tx_full <= 1'b1;
        r_tx_hold <= r_spi_in;
      end else if (w_tx_load || w_brk_hit) r_tx_full <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spi_busy <= 1'b0;
      r_spi_done <= 1'b0;
      r_spi_cnt  <= 4'd0;
      r_spi_sr   <= 7'd0;
      r_spi_in   <= 8'h00;
      r_sck      <= 1'b0;
      r_so       <= 1'b0;
    end else begin
      r_spi_done <= 1'b0;
      if (w_brk_hit) begin
        r_spi_busy <= 1'b0;
        r_sck      <= 1'b0;
        r_so       <= 1'b0;
      end else if (w_spi_start) begin
        r_spi_busy <= 1'b1;
        r_spi_cnt  <= 4'd0;
        r_spi_sr   <= w_spi_data[6:0];
        r_so       <= w_spi_data[7];
      end else if (r_spi_busy) begin
        r_sck     <= !r_sck;
        r_spi_cnt <= r_spi_cnt + 1'b1;
        r_spi_in  <= r_sck ? r_spi_in : {r_spi_in[6:0], spi_si};
        r_spi_sr  <= r_sck ? {r_spi_sr[5:0], 1'b0} : r_spi_sr;
        r_so      <= r_sck ? r_spi_sr[6] : r_so;
        r_spi_busy <= r_spi_cnt != 4'd15;
        r_spi_done <= r_spi_cnt == 4'd15;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ss    <= 1'b1;
      r_boot  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ss    <= !(w_next == XFER_TX || w_next == XFER_RX);
      r_boot  <= r_boot || w_next == BOOT;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (r_rx_vld) w_next = r_rx_sr == 8'h01 ? TXL0 : r_rx_sr == 8'h00 ? BOOT : IDLE;
      TXL0:    if (r_rx_vld) w_next = TXL1;
      TXL1:    if (r_rx_vld) w_next = RXL0;
      RXL0:    if (r_rx_vld) w_next = RXL1;
      RXL1:    if (r_rx_vld) w_next = r_tx_len != 16'd0 ? XFER_TX : {r_rx_sr, r_rx_len[7:0]} != 16'd0 ? XFER_RX : IDLE;
      XFER_TX: if (r_tx_len == 16'd0 && !r_spi_busy) w_next = r_rx_len != 16'd0 ? XFER_RX : IDLE;
      XFER_RX: if (r_rx_len == 16'd0 && !r_spi_busy && !r_spi_done) w_next = IDLE;
      default: w_next = r_state;
    endcase
    if (w_brk_hit && r_state != BOOT) w_next = IDLE;
  end
  // A read byte only starts once its predecessor has left the TX holding register.
  always_comb begin
    w_spi_start = !w_brk_hit && !r_spi_busy &&
                  ((r_state == XFER_TX && r_rx_vld && r_tx_len != 16'd0) ||
                   (r_state == XFER_RX && r_rx_len != 16'd0 && !r_spi_done && !r_tx_full));
    w_spi_data  = r_state == XFER_TX ? r_rx_sr : 8'h00;
    w_tx_q      = !w_brk_hit && r_state == XFER_RX && r_spi_done;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_len <= 16'd0;
      r_rx_len <= 16'd0;
    end else if (w_brk_hit && r_state != BOOT) begin
      r_tx_len <= 16'd0;
      r_rx_len <= 16'd0;
    end else if (r_rx_vld && r_state == TXL0) r_tx_len[7:0] <= r_rx_sr;
    else if (r_rx_vld && r_state == TXL1) r_tx_len[15:8] <= r_rx_sr;
    else if (r_rx_vld && r_state == RXL0) r_rx_len[7:0] <= r_rx_sr;
    else if (r_rx_vld && r_state == RXL1) r_rx_len[15:8] <= r_rx_sr;
    else if (w_spi_start && r_state == XFER_TX) r_tx_len <= r_tx_len - 1'b1;
    else if (w_spi_start) r_rx_len <= r_rx_len - 1'b1;
  end
endmodule

// File: tb/tb_bootloader_top.sv
// tb_bootloader_top: directed command frames with expected SPI/UART traffic queued for decoupled monitors.
module tb_bootloader_top;
  localparam int BIT = 16;
  logic clk = 1'b0;
  logic rst_n, uart0_rx, spi_si;
  logic uart0_tx, spi_sck, spi_so, spi_ss, boot;
  int passed = 0;
  int total = 0;
  bit ign = 1'b0;
  logic [7:0] exp_uart[$];
  logic [7:0] exp_mosi[$];
  int exp_win[$];
  logic [7:0] cmd[$];
  bootloader_top #(.CLK_FREQ(12000000), .UART_BAUDRATE(750000)) dut (
    .clk(clk), .rst_n(rst_n), .uart0_rx(uart0_rx), .uart0_tx(uart0_tx),
    .spi_sck(spi_sck), .spi_so(spi_so), .spi_si(spi_si), .spi_ss(spi_ss), .boot(boot)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask
  task automatic fail(input string name, input int act);
    total++;
    $display("FAIL %s: got %0h, required nothing", name, act);
  endtask
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart0_rx = 1'b0;
    clks(BIT);
    for (int i = 0; i < 8; i++) begin
      uart0_rx = b[i];
      clks(BIT);
    end
    uart0_rx = stop;
    clks(BIT);
    uart0_rx = 1'b1;
  endtask
  task automatic send_cmd();
    foreach (cmd[k]) send_frame(cmd[k], 1'b1);
  endtask
  task automatic drain();
    int n = 0;
    while (exp_uart.size() + exp_mosi.size() + exp_win.size() != 0 && n < 4000) begin
      clks(1);
      n++;
    end
    check("drain_outstanding", exp_uart.size() + exp_mosi.size() + exp_win.size(), 0);
    clks(2 * BIT);
  endtask
  task automatic id_read();
    spi_si = 1'b0;
    exp_win.push_back(56);
    exp_mosi.push_back(8'h9F);
    for (int i = 0; i < 6; i++) exp_mosi.push_back(8'h00);
    for (int i = 0; i < 5; i++) exp_uart.push_back(8'h00);
    cmd = {8'h01, 8'h02, 8'h00, 8'h05, 8'h00, 8'h9F, 8'h00};
    send_cmd();
    drain();
  endtask
  task automatic read_one_ff();
    spi_si = 1'b1;
    exp_win.push_back(8);
    exp_mosi.push_back(8'h00);
    exp_uart.push_back(8'hFF);
    cmd = {8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
    send_cmd();
    drain();
  endtask
  initial begin : uart_mon
    logic [7:0] b;
    logic stp;
    forever begin
      @(negedge clk);
      if (!uart0_tx && rst_n) begin
        clks(BIT / 2);
        for (int i = 0; i < 8; i++) begin
          clks(BIT);
          b[i] = uart0_tx;
        end
        clks(BIT);
        stp = uart0_tx;
        if (!ign) begin
          if (exp_uart.size() == 0) fail("uart_unexpected_byte", {stp, b});
          else check("uart_byte_with_stop", {stp, b}, {1'b1, exp_uart.pop_front()});
        end
      end
    end
  end
  initial begin : spi_mon
    logic prev_sck, prev_ss;
    int rises;
    logic [7:0] sh;
    prev_sck = 1'b0;
    prev_ss = 1'b1;
    rises = 0;
    sh = 8'h00;
    forever begin
      @(negedge clk);
      if (prev_ss && !spi_ss) rises = 0;
      if (spi_sck && !prev_sck) begin
        if (spi_ss) begin
          if (!ign) fail("sck_rise_outside_ss", rises);
        end else begin
          rises++;
          sh = {sh[6:0], spi_so};
          if (rises % 8 == 0 && !ign) begin
            if (exp_mosi.size() == 0) fail("mosi_unexpected_byte", sh);
            else check("mosi_byte", sh, exp_mosi.pop_front());
          end
        end
      end
      if (!prev_ss && spi_ss && !ign) begin
        if (exp_win.size() == 0) fail("ss_unexpected_window", rises);
        else check("sck_rises_in_window", rises, exp_win.pop_front());
      end
      prev_sck = spi_sck;
      prev_ss = spi_ss;
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0;
    uart0_rx = 1'b1;
    spi_si = 1'b0;
    clks(3);
    check("reset_uart0_tx", uart0_tx, 1);
    check("reset_spi_sck", spi_sck, 0);
    check("reset_spi_so", spi_so, 0);
    check("reset_spi_ss", spi_ss, 1);
    check("reset_boot", boot, 0);
    rst_n = 1'b1;
    clks(4 * BIT);
    send_frame(8'h00, 1'b0);
    clks(2 * BIT);
    check("framing_error_not_boot", boot, 0);
    id_read();
    cmd = {8'h01, 8'h02, 8'h00};
    send_cmd();
    uart0_rx = 1'b0;
    clks(19 * BIT);
    uart0_rx = 1'b1;
    clks(2 * BIT);
    check("break_ss_high", spi_ss, 1);
    check("break_not_boot", boot, 0);
    id_read();
    check("after_break_boot", boot, 0);
    exp_win.push_back(8);
    exp_mosi.push_back(8'h06);
    exp_win.push_back(32);
    exp_mosi.push_back(8'hD8);
    exp_mosi.push_back(8'h02);
    exp_mosi.push_back(8'h00);
    exp_mosi.push_back(8'h00);
    cmd = {8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h06,
           8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'hD8, 8'h02, 8'h00, 8'h00};
    send_cmd();
    drain();
    read_one_ff();
    cmd = {8'h00};
    send_cmd();
    check("boot_after_stop", boot, 1);
    clks(4 * BIT);
    cmd = {8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
    send_cmd();
    clks(4 * BIT);
    check("boot_sticky", boot, 1);
    check("boot_ignores_input_ss", spi_ss, 1);
    rst_n = 1'b0;
    #1;
    check("reset_clears_boot", boot, 0);
    clks(2);
    rst_n = 1'b1;
    clks(2);
    ign = 1'b1;
    spi_si = 1'b0;
    cmd = {8'h01, 8'h00, 8'h00, 8'h03, 8'h00};
    send_cmd();
    clks(3 * BIT);
    check("xfer_rx_ss_low", spi_ss, 0);
    rst_n = 1'b0;
    #1;
    check("midreset_spi_ss", spi_ss, 1);
    check("midreset_spi_sck", spi_sck, 0);
    check("midreset_spi_so", spi_so, 0);
    check("midreset_uart0_tx", uart0_tx, 1);
    check("midreset_boot", boot, 0);
    clks(2);
    rst_n = 1'b1;
    clks(12 * BIT);
    ign = 1'b0;
    read_one_ff();
    check("final_queues_empty", exp_uart.size() + exp_mosi.size() + exp_win.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bootloader_top.md
# bootloader_top

UART-to-SPI bridge bootloader for an FPGA with attached SPI flash. A host sends framed commands over a 115200 8N1 UART. The block runs the corresponding SPI flash transactions: sends host bytes, reads flash bytes and returns them over the UART. A dedicated command triggers boot of the user image. It is the top level of the bootloader design and connects directly to the UART and flash pins.

## Interface
- CLK_FREQ, 12000000: clk frequency in Hz.
- UART_BAUDRATE, 115200: UART bit rate; bit period = CLK_FREQ/UART_BAUDRATE cycles (integer division, 104 at defaults).
- clk  in  1  system clock.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- uart0_rx  in  1  UART receive, idle high.
- uart0_tx  out  1  UART transmit, idle high.
- spi_sck  out  1  SPI clock, mode 0.
- spi_so  out  1  SPI MOSI.
- spi_si  in  1  SPI MISO.
- spi_ss  out  1  SPI chip select, active low.
- boot  out  1  boot request to the warmboot primitive.

## Operation
- **UART RX**
  - 8N1, LSB first, sampled at mid-bit.
  - A byte whose stop bit is low (framing error) is discarded.
- **UART TX**
  - 8N1 with a single-byte holding register and a ready flag.
- **Break**
  - uart0_rx low continuously for ≥16 bit periods is a break.
  - Break aborts any command: spi_ss→1, spi_sck→0, counters cleared, parser to IDLE, pending reply bytes dropped.
  - A UART TX byte already shifting completes normally.
  - Nothing is accepted until uart0_rx has returned high.
- **Parser states**: IDLE, TXL0, TXL1, RXL0, RXL1, XFER_TX, XFER_RX, BOOT.
- **IDLE**
  - Byte 0x01 → TXL0.
  - Byte 0x00 → BOOT.
  - Any other byte is ignored.
- **Transfer header**
  - TXL0/TXL1 capture tx_len, a 16-bit little-endian count.
  - RXL0/RXL1 capture rx_len, a 16-bit little-endian count.
- **After header**
  - tx_len>0 → XFER_TX.
  - tx_len=0 and rx_len>0 → XFER_RX.
  - Both 0 → IDLE with no SPI activity.
- **spi_ss**: driven low on entering XFER_TX or XFER_RX; held low until the last byte of the transfer completes.
- **XFER_TX**
  - Each received UART byte is shifted out MSB first; MISO is ignored.
  - After tx_len bytes → XFER_RX if rx_len>0, else end.
- **XFER_RX**
  - Shifts out 0x00 on MOSI and captures MISO MSB first.
  - Each captured byte is queued to the UART TX; the next SPI byte does not start until the TX holding register is free.
  - spi_ss stays low during such pauses.
  - After rx_len bytes → end.
- **End of transfer**: spi_ss→1 and the parser → IDLE. The block sends no acknowledge or status bytes; only rx data is returned.
- **BOOT**: boot latches 1 and stays high until reset; further input is ignored.
- **SPI timing**
  - spi_sck = clk/2.
  - MOSI changes on the falling edge; MISO is sampled on the rising edge.
  - spi_sck idles at 0.

## Timing
- Reset values: uart0_tx=1, spi_sck=0, spi_so=0, spi_ss=1, boot=0; parser IDLE, lengths 0.
- rst_n asserted mid-transfer returns all outputs to reset values immediately (asynchronous).
- **SPI byte**: 16 clk cycles, with 8 rising sck edges.
  - First SPI byte starts ≤4 clk after the UART byte is accepted (XFER_TX) or after RXL1 is accepted (XFER_RX).
  - spi_ss falls ≥1 clk before the first sck rise.
  - spi_ss rises ≥1 clk after the last sck fall.
- **UART**
  - RX byte is valid within 1 bit period after the stop-bit midpoint.
  - TX start bit begins ≤2 clk after a byte is queued.
  - Back-to-back TX bytes have no idle gap.
- A new 0x01 command arriving immediately after a transfer ends must be accepted; the parser is back in IDLE before the next start bit completes.
- 16-bit counters: a length of 0xFFFF is valid; there is no wrap beyond it.

## Test plan
- **Flash ID read**
  - Stimulus: spi_si=0; send 01 02 00 05 00 9F 00.
  - Required: spi_ss low; 56 sck rises; MOSI bytes 9F, 00, then five 00; UART returns five 0x00 bytes; spi_ss high at the end.
- **Break abort**
  - Stimulus: send 01 02 00; hold RX low for 19 bit periods; release; then send the full ID read.
  - Required: no SPI activity and no UART output from the aborted command; the ID read then behaves exactly as in the first scenario; the break is not taken as boot, so boot stays 0.
- **Back-to-back writes**
  - Stimulus: send 01 01 00 00 00 06, then immediately 01 04 00 00 00 D8 02 00 00.
  - Required: two separate spi_ss low windows of 8 and 32 sck cycles with MOSI 06 and D8 02 00 00; no UART output.
- **Read-only transfer**
  - Stimulus: send 01 00 00 01 00 with spi_si=1.
  - Required: one spi_ss window of 8 sck cycles; UART returns 0xFF.
- **Boot**
  - Stimulus: send 00 from IDLE.
  - Required: boot=1 within one bit period after the stop bit; stays 1.
- **Reset mid-transfer**
  - Stimulus: pulse rst_n low during XFER_RX.
  - Required: spi_ss=1, spi_sck=0, uart0_tx=1, boot=0 immediately.
